// File: rtl/conv_pkg.sv
// Shared constants and types for the conv engine result collector.
// Engine state codes mirror the top-level display_current_state encoding.
package conv_pkg;

  localparam int unsigned ConvDw = 8;
  localparam int unsigned ConvSw = 3;

  localparam logic [2:0] ENG_SINGLE = 3'd1;
  localparam logic [2:0] ENG_SYS3   = 3'd2;
  localparam logic [2:0] ENG_SYS2   = 3'd3;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StCapt,
    StCmp,
    StDone
  } coll_state_e;

endpackage

// File: rtl/conv_result_collector_if.sv
// Display stream, readback and status bundle between the conv top and the collector.
interface conv_result_collector_if
  import conv_pkg::*;
#(
  parameter int unsigned DW = ConvDw,
  parameter int unsigned SW = ConvSw
);

  logic          arm;
  logic [DW-1:0] display_result;
  logic [SW-1:0] display_current_state;
  logic [3:0]    rd_idx;
  logic [DW-1:0] rd_data;
  logic          done;
  logic          match;
  logic [3:0]    mismatch_mask;
  logic          err_order;
  logic          err_timeout;

  modport master (
    output arm, display_result, display_current_state, rd_idx,
    input  rd_data, done, match, mismatch_mask, err_order, err_timeout
  );

  modport slave (
    input  arm, display_result, display_current_state, rd_idx,
    output rd_data, done, match, mismatch_mask, err_order, err_timeout
  );

endinterface

// File: rtl/result_cmp4.sv
// Combinational 3-way comparator over the four 2x2 output positions.
module result_cmp4 #(
  parameter int unsigned DW = 8
) (
  input  logic [3:0][DW-1:0] e0,
  input  logic [3:0][DW-1:0] e1,
  input  logic [3:0][DW-1:0] e2,
  output logic [3:0]         mask
);

  always_comb begin
    mask = '0;
    for (int p = 0; p < 4; p++) begin
      mask[p] = (e0[p] != e1[p]) | (e0[p] != e2[p]);
    end
  end

endmodule

// File: rtl/conv_result_collector.sv
// Captures the 2x2 results of the three conv engines from the display stream,
// cross-checks them and serves the captured bytes by index.
module conv_result_collector
  import conv_pkg::*;
#(
  parameter int unsigned DW      = ConvDw,
  parameter int unsigned SW      = ConvSw,
  parameter int unsigned TIMEOUT = 255
) (
  input logic                   clk,
  input logic                   reset,
  conv_result_collector_if.slave bus
);

  localparam int unsigned GapW = $clog2(TIMEOUT + 2);

  coll_state_e        state_q, state_d;
  logic [1:0]         eng_q, eng_d;
  logic [2:0]         pos_q, pos_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic               match_q, match_d;
  logic [3:0]         mask_q, mask_d;
  logic               err_order_q, err_order_d;
  logic               err_timeout_q, err_timeout_d;
  logic [11:0][DW-1:0] cap_q;
  logic [DW-1:0]      rd_q;

  logic       wr_en;
  logic [3:0] wr_addr;
  logic       clr;
  logic       is_eng;
  logic [1:0] code_eng;
  logic       fail;
  logic [3:0] cmp_mask;

  result_cmp4 #(
    .DW(DW)
  ) u_cmp (
    .e0  (cap_q[3:0]),
    .e1  (cap_q[7:4]),
    .e2  (cap_q[11:8]),
    .mask(cmp_mask)
  );

  always_comb begin
    is_eng   = 1'b1;
    code_eng = 2'd0;
    if (bus.display_current_state == SW'(ENG_SINGLE)) begin
      code_eng = 2'd0;
    end else if (bus.display_current_state == SW'(ENG_SYS3)) begin
      code_eng = 2'd1;
    end else if (bus.display_current_state == SW'(ENG_SYS2)) begin
      code_eng = 2'd2;
    end else begin
      is_eng = 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    eng_d         = eng_q;
    pos_d         = pos_q;
    gap_d         = gap_q;
    match_d       = match_q;
    mask_d        = mask_q;
    err_order_d   = err_order_q;
    err_timeout_d = err_timeout_q;
    wr_en         = 1'b0;
    wr_addr       = {eng_q, pos_q[1:0]};
    clr           = 1'b0;
    fail          = 1'b0;

    // arm wins over any same-cycle sample in every state
    if (bus.arm) begin
      clr           = 1'b1;
      state_d       = StWait;
      eng_d         = 2'd0;
      pos_d         = 3'd0;
      gap_d         = '0;
      match_d       = 1'b0;
      mask_d        = 4'h0;
      err_order_d   = 1'b0;
      err_timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StWait: begin
          if (is_eng && code_eng == 2'd0) begin
            wr_en   = 1'b1;
            wr_addr = 4'd0;
            eng_d   = 2'd0;
            pos_d   = 3'd1;
            gap_d   = '0;
            state_d = StCapt;
          end
        end
        StCapt: begin
          if (is_eng && code_eng == eng_q && pos_q < 3'd4) begin
            wr_en = 1'b1;
            pos_d = pos_q + 3'd1;
            gap_d = '0;
            if (eng_q == 2'd2 && pos_q == 3'd3) state_d = StCmp;
          end else if (is_eng && pos_q == 3'd4 && code_eng == eng_q + 2'd1) begin
            wr_en   = 1'b1;
            wr_addr = {eng_q + 2'd1, 2'd0};
            eng_d   = eng_q + 2'd1;
            pos_d   = 3'd1;
            gap_d   = '0;
          end else if (!is_eng && pos_q == 3'd4) begin
            gap_d = gap_q + GapW'(1);
            if (32'(gap_q) >= TIMEOUT) begin
              err_timeout_d = 1'b1;
              fail          = 1'b1;
            end
          end else begin
            err_order_d = 1'b1;
            fail        = 1'b1;
          end
        end
        StCmp: begin
          mask_d  = cmp_mask;
          match_d = ~|cmp_mask;
          state_d = StDone;
        end
        StDone: ;
        default: state_d = StIdle;
      endcase

      if (fail) begin
        match_d = 1'b0;
        mask_d  = 4'hF;
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      eng_q         <= 2'd0;
      pos_q         <= 3'd0;
      gap_q         <= '0;
      match_q       <= 1'b0;
      mask_q        <= 4'h0;
      err_order_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      cap_q         <= '0;
      rd_q          <= '0;
    end else begin
      state_q       <= state_d;
      eng_q         <= eng_d;
      pos_q         <= pos_d;
      gap_q         <= gap_d;
      match_q       <= match_d;
      mask_q        <= mask_d;
      err_order_q   <= err_order_d;
      err_timeout_q <= err_timeout_d;
      if (clr) begin
        cap_q <= '0;
      end else if (wr_en) begin
        cap_q[wr_addr] <= bus.display_result;
      end
      rd_q <= (bus.rd_idx < 4'd12) ? cap_q[bus.rd_idx] : '0;
    end
  end

  assign bus.rd_data       = rd_q;
  assign bus.done          = (state_q == StDone);
  assign bus.match         = match_q;
  assign bus.mismatch_mask = mask_q;
  assign bus.err_order     = err_order_q;
  assign bus.err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector: consistent, faulty, order, timeout,
// reset and re-arm scenarios with hand-computed expectations.
module tb_conv_result_collector;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] vec [12];

  always #5 clk = ~clk;

  conv_result_collector_if #(.DW(8), .SW(3)) bus ();

  conv_result_collector #(
    .DW     (8),
    .SW     (3),
    .TIMEOUT(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input int idx, input logic [7:0] exp);
    bus.rd_idx = 4'(idx);
    tick();
    check(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic do_arm();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  // engines 1..3 in order, `gap` idle cycles between engines, then two settle cycles
  task automatic send_stream(input int gap);
    for (int e = 0; e < 3; e++) begin
      if (e > 0) begin
        for (int g = 0; g < gap; g++) begin
          bus.display_current_state = 3'd0;
          tick();
        end
      end
      for (int p = 0; p < 4; p++) begin
        bus.display_current_state = 3'(e + 1);
        bus.display_result        = vec[e * 4 + p];
        tick();
      end
    end
    bus.display_current_state = 3'd0;
    tick();
    tick();
  endtask

  task automatic load_vec(input logic [7:0] a, b, c, d);
    for (int e = 0; e < 3; e++) begin
      vec[e * 4 + 0] = a;
      vec[e * 4 + 1] = b;
      vec[e * 4 + 2] = c;
      vec[e * 4 + 3] = d;
    end
  endtask

  task automatic status_chk(input string tag, input logic dn, input logic mt,
                            input logic [3:0] mk, input logic eo, input logic et);
    check({tag, "_done"}, 32'(bus.done), 32'(dn));
    check({tag, "_match"}, 32'(bus.match), 32'(mt));
    check({tag, "_mask"}, 32'(bus.mismatch_mask), 32'(mk));
    check({tag, "_eord"}, 32'(bus.err_order), 32'(eo));
    check({tag, "_etmo"}, 32'(bus.err_timeout), 32'(et));
  endtask

  initial begin
    reset                     = 1'b0;
    bus.arm                   = 1'b0;
    bus.display_result        = 8'd0;
    bus.display_current_state = 3'd0;
    bus.rd_idx                = 4'd0;
    tick();
    tick();
    status_chk("reset", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    check("reset_rd", 32'(bus.rd_data), 32'd0);
    reset = 1'b1;

    // codes before arm are ignored
    bus.display_current_state = 3'd1;
    bus.display_result        = 8'd77;
    tick();
    tick();
    bus.display_current_state = 3'd0;
    tick();
    check("idle_done", 32'(bus.done), 32'd0);
    rd_chk("idle_rd0", 0, 8'd0);

    // consistent stream
    load_vec(8'd202, 8'd17, 8'd99, 8'd255);
    do_arm();
    send_stream(0);
    status_chk("ok", 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    rd_chk("ok_rd0", 0, 8'd202);
    rd_chk("ok_rd4", 4, 8'd202);
    rd_chk("ok_rd8", 8, 8'd202);
    rd_chk("ok_rd11", 11, 8'd255);
    rd_chk("ok_rd12", 12, 8'd0);
    rd_chk("ok_rd15", 15, 8'd0);

    // faulty SYS3 c21, with a legal 3-cycle gap between engines
    vec[6] = 8'd201;
    do_arm();
    status_chk("rearm", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    send_stream(3);
    status_chk("bad", 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0);
    rd_chk("bad_rd6", 6, 8'd201);
    rd_chk("bad_rd2", 2, 8'd99);
    rd_chk("bad_rd10", 10, 8'd99);

    // order error: SINGLE x4 then SYS2
    load_vec(8'd1, 8'd2, 8'd3, 8'd4);
    do_arm();
    for (int p = 0; p < 4; p++) begin
      bus.display_current_state = 3'd1;
      bus.display_result        = vec[p];
      tick();
    end
    bus.display_current_state = 3'd3;
    tick();
    bus.display_current_state = 3'd0;
    status_chk("order", 1'b1, 1'b0, 4'hF, 1'b1, 1'b0);

    // gap exactly TIMEOUT is still legal
    do_arm();
    send_stream(4);
    status_chk("gap4", 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);

    // gap beyond TIMEOUT
    do_arm();
    send_stream(6);
    status_chk("tmo", 1'b1, 1'b0, 4'hF, 1'b0, 1'b1);

    // reset after two SYS3 samples
    load_vec(8'd40, 8'd41, 8'd42, 8'd43);
    do_arm();
    for (int i = 0; i < 6; i++) begin
      bus.display_current_state = (i < 4) ? 3'd1 : 3'd2;
      bus.display_result        = vec[i];
      tick();
    end
    reset = 1'b0;
    tick();
    status_chk("rst_mid", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    check("rst_mid_rd", 32'(bus.rd_data), 32'd0);
    reset = 1'b1;
    send_stream(0);
    check("rst_ign_done", 32'(bus.done), 32'd0);
    rd_chk("rst_ign_rd0", 0, 8'd0);

    // re-arm with fresh values
    load_vec(8'd5, 8'd6, 8'd7, 8'd8);
    do_arm();
    send_stream(1);
    status_chk("fresh", 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    rd_chk("fresh_rd0", 0, 8'd5);
    rd_chk("fresh_rd7", 7, 8'd8);
    rd_chk("fresh_rd9", 9, 8'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
